// File: rtl/signed_add_arbiter.sv
// signed_add_arbiter
// Two requesters share a single WIDTH-bit two's-complement adder. A
// round-robin arbiter picks one requester per cycle, and the sum lands in a
// one-deep result register. A saturating 8-bit counter tallies accepted
// additions that overflowed.
//
// Handshake semantics (all three channels):
//   A transfer happens on a rising edge where valid and ready are both high.
//   reqN_ready is combinational. It is high only while this requester holds
//   the grant and the result register can take a new value. A requester may
//   drop valid at any time without a transfer, and that changes no state.
//   res_valid stays high and res_sum/res_overflow/res_id stay stable until
//   res_ready is seen high. A new result may load in the same cycle the old
//   one is delivered, so results stream back-to-back at one per cycle.
module signed_add_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_overflow,
  output logic             res_id,
  input  logic             ovf_clear,
  output logic [7:0]       ovf_cnt
);

  localparam int MSB = WIDTH - 1;
  localparam logic [7:0] CNT_MAX = 8'hFF;

  // Round-robin pointer: 1 means requester 1 won the last accepted transfer,
  // so requester 0 wins the next contention. Reset leaves it at 1.
  logic             last_grant_q;
  logic             last_grant_d;

  // Result register and overflow counter.
  logic             res_valid_q;
  logic             res_valid_d;
  logic [WIDTH-1:0] res_sum_q;
  logic [WIDTH-1:0] res_sum_d;
  logic             res_ovf_q;
  logic             res_ovf_d;
  logic             res_id_q;
  logic             res_id_d;
  logic [7:0]       ovf_cnt_q;
  logic [7:0]       ovf_cnt_d;

  // Arbitration and datapath nets.
  logic             grant0;
  logic             grant1;
  logic             can_accept;
  logic             accept;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] add_sum;
  logic             add_ovf;

  // Grant selection. The grant depends only on the valids and the pointer,
  // never on the other side's ready, so neither ready feeds into the other.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      if (last_grant_q) begin
        grant0 = 1'b1;
      end else begin
        grant1 = 1'b1;
      end
    end else if (req0_valid) begin
      grant0 = 1'b1;
    end else if (req1_valid) begin
      grant1 = 1'b1;
    end
  end

  // The result register is free when it is empty or drains this cycle.
  // rst_n gates the readies so that nothing is accepted while reset is held.
  always_comb begin
    can_accept = !res_valid_q || res_ready;
    req0_ready = grant0 && can_accept && rst_n;
    req1_ready = grant1 && can_accept && rst_n;
    accept     = req0_ready || req1_ready;
  end

  // One adder serves both requesters through an operand mux steered by the
  // grant. Overflow is signalled when both operands have the same sign and
  // the wrapped sum has the other sign.
  always_comb begin
    op_a    = grant1 ? req1_a : req0_a;
    op_b    = grant1 ? req1_b : req0_b;
    add_sum = op_a + op_b;
    add_ovf = (op_a[MSB] == op_b[MSB]) && (add_sum[MSB] != op_a[MSB]);
  end

  // Next-state for the result register and the round-robin pointer.
  always_comb begin
    res_valid_d  = res_valid_q;
    res_sum_d    = res_sum_q;
    res_ovf_d    = res_ovf_q;
    res_id_d     = res_id_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      res_valid_d  = 1'b1;
      res_sum_d    = add_sum;
      res_ovf_d    = add_ovf;
      res_id_d     = grant1;
      last_grant_d = grant1;
    end else if (res_ready) begin
      // Delivered with nothing new behind it. The data fields keep their
      // old values, which is harmless because res_valid is low.
      res_valid_d = 1'b0;
    end
  end

  // Overflow counter next-state: clear takes priority, and the count
  // saturates at 255.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (ovf_clear) begin
      ovf_cnt_d = 8'd0;
    end else if (accept && add_ovf && (ovf_cnt_q != CNT_MAX)) begin
      ovf_cnt_d = ovf_cnt_q + 8'd1;
    end
  end

  // State registers. An asynchronous reset discards any pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q  <= 1'b0;
      res_sum_q    <= '0;
      res_ovf_q    <= 1'b0;
      res_id_q     <= 1'b0;
      ovf_cnt_q    <= 8'd0;
      last_grant_q <= 1'b1;
    end else begin
      res_valid_q  <= res_valid_d;
      res_sum_q    <= res_sum_d;
      res_ovf_q    <= res_ovf_d;
      res_id_q     <= res_id_d;
      ovf_cnt_q    <= ovf_cnt_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Drive the outputs from the registers.
  always_comb begin
    res_valid    = res_valid_q;
    res_sum      = res_sum_q;
    res_overflow = res_ovf_q;
    res_id       = res_id_q;
    ovf_cnt      = ovf_cnt_q;
  end

endmodule

// File: tb/tb_signed_add_arbiter.sv
// tb_signed_add_arbiter
// Directed bench for signed_add_arbiter (WIDTH=4). Each accepted operation
// pushes its hand-computed {id, overflow, sum} onto exp_q. The monitor pops
// and compares an entry whenever a result is delivered (res_valid && res_ready).
module tb_signed_add_arbiter;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         req0_valid;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req0_ready;
  logic         req1_valid;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         req1_ready;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_sum;
  logic         res_overflow;
  logic         res_id;
  logic         ovf_clear;
  logic [7:0]   ovf_cnt;

  // Each entry is {id, overflow, sum}.
  logic [W+1:0] exp_q[$];
  int           n_checks;
  int           n_fail;

  signed_add_arbiter #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .req1_ready   (req1_ready),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_sum      (res_sum),
    .res_overflow (res_overflow),
    .res_id       (res_id),
    .ovf_clear    (ovf_clear),
    .ovf_cnt      (ovf_cnt)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drivers. Inputs change at posedge+1. Readies are checked at the
  // following negedge, and the task returns at the next posedge+1.
  task automatic cycle(input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                       input logic v1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                       input logic rr, input logic e0, input logic e1);
    req0_valid = v0;
    req0_a     = a0;
    req0_b     = b0;
    req1_valid = v1;
    req1_a     = a1;
    req1_b     = b1;
    res_ready  = rr;
    @(negedge clk);
    check("req0_ready", {31'd0, req0_ready}, {31'd0, e0});
    check("req1_ready", {31'd0, req1_ready}, {31'd0, e1});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rr);
    cycle(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, rr, 1'b0, 1'b0);
  endtask

  task automatic push(input logic id, input logic ovf, input logic [W-1:0] sum);
    exp_q.push_back({id, ovf, sum});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: pops one expected entry per delivered result.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL result_unexpected: got id=%0d sum=0x%0h with empty queue at %0t",
                 res_id, res_sum, $time);
      end else begin
        check("result", {26'd0, res_id, res_overflow, res_sum}, {26'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    int waited;
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_a     = 4'h1;
    req0_b     = 4'h1;
    req1_a     = 4'h1;
    req1_b     = 4'h1;
    res_ready  = 1'b1;
    ovf_clear  = 1'b0;

    // Reset state: outputs cleared, and no ready even with both requesting.
    #3;
    check("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    check("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_res_sum", {28'd0, res_sum}, 32'd0);
    check("rst_res_id", {31'd0, res_id}, 32'd0);
    check("rst_ovf_cnt", {24'd0, ovf_cnt}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 7 + 1 wraps to -8 with overflow.
    push(1'b0, 1'b1, 4'h8);
    cycle(1'b1, 4'h7, 4'h1, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0);
    check("res_valid_lat1", {31'd0, res_valid}, 32'd1);
    check("ovf_cnt_1", {24'd0, ovf_cnt}, 32'd1);
    // -8 + -1 wraps to 7 with overflow.
    push(1'b1, 1'b1, 4'h7);
    cycle(1'b0, 4'h0, 4'h0, 1'b1, 4'h8, 4'hF, 1'b1, 1'b0, 1'b1);
    check("ovf_cnt_2", {24'd0, ovf_cnt}, 32'd2);
    // 5 + -3 = 2 without overflow.
    push(1'b0, 1'b0, 4'h2);
    cycle(1'b1, 4'h5, 4'hD, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0);
    check("ovf_cnt_still_2", {24'd0, ovf_cnt}, 32'd2);
    idle(1'b1);
    check("res_valid_drained", {31'd0, res_valid}, 32'd0);

    // Contention after reset: ids alternate 0,1,0,1, one per cycle.
    // req0: 1+2=3. req1: -2+-3=-5 (0xB), neither overflows.
    do_reset();
    push(1'b0, 1'b0, 4'h3);
    cycle(1'b1, 4'h1, 4'h2, 1'b1, 4'hE, 4'hD, 1'b1, 1'b1, 1'b0);
    push(1'b1, 1'b0, 4'hB);
    cycle(1'b1, 4'h1, 4'h2, 1'b1, 4'hE, 4'hD, 1'b1, 1'b0, 1'b1);
    push(1'b0, 1'b0, 4'h3);
    cycle(1'b1, 4'h1, 4'h2, 1'b1, 4'hE, 4'hD, 1'b1, 1'b1, 1'b0);
    push(1'b1, 1'b0, 4'hB);
    cycle(1'b1, 4'h1, 4'h2, 1'b1, 4'hE, 4'hD, 1'b1, 1'b0, 1'b1);

    // Stall for 3 cycles: result held, no readies, pointer unchanged.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 4'h1, 4'h2, 1'b1, 4'hE, 4'hD, 1'b0, 1'b0, 1'b0);
      check("stall_valid", {31'd0, res_valid}, 32'd1);
      check("stall_sum", {28'd0, res_sum}, 32'h0000000B);
      check("stall_id", {31'd0, res_id}, 32'd1);
    end
    // A requester dropping valid during the stall is harmless.
    cycle(1'b0, 4'h0, 4'h0, 1'b1, 4'hE, 4'hD, 1'b0, 1'b0, 1'b0);
    // Resume: the last grant went to 1, so 0 goes next.
    push(1'b0, 1'b0, 4'h3);
    cycle(1'b1, 4'h1, 4'h2, 1'b1, 4'hE, 4'hD, 1'b1, 1'b1, 1'b0);
    push(1'b1, 1'b0, 4'hB);
    cycle(1'b1, 4'h1, 4'h2, 1'b1, 4'hE, 4'hD, 1'b1, 1'b0, 1'b1);
    idle(1'b1);

    // 256 overflowing operations saturate the counter at 255.
    ovf_clear = 1'b1;
    idle(1'b1);
    ovf_clear = 1'b0;
    check("ovf_cnt_cleared", {24'd0, ovf_cnt}, 32'd0);
    for (int i = 0; i < 256; i++) begin
      push(1'b0, 1'b1, 4'h8);
      cycle(1'b1, 4'h7, 4'h1, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0);
    end
    check("ovf_cnt_sat", {24'd0, ovf_cnt}, 32'd255);
    // Clear wins over a simultaneous overflow increment.
    ovf_clear = 1'b1;
    push(1'b1, 1'b1, 4'h7);
    cycle(1'b0, 4'h0, 4'h0, 1'b1, 4'h8, 4'hF, 1'b1, 1'b0, 1'b1);
    ovf_clear = 1'b0;
    check("ovf_cnt_clear_wins", {24'd0, ovf_cnt}, 32'd0);
    idle(1'b1);

    // Reset while a result is pending: the result is discarded and the
    // counter clears.
    push(1'b1, 1'b1, 4'h7);
    cycle(1'b0, 4'h0, 4'h0, 1'b1, 4'h8, 4'hF, 1'b1, 1'b0, 1'b1);
    check("ovf_cnt_pre_rst", {24'd0, ovf_cnt}, 32'd1);
    res_ready  = 1'b0;
    req1_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_res_valid", {31'd0, res_valid}, 32'd0);
    check("midrst_ovf_cnt", {24'd0, ovf_cnt}, 32'd0);
    check("midrst_res_sum", {28'd0, res_sum}, 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // The first contention after reset goes to requester 0.
    push(1'b0, 1'b0, 4'h3);
    cycle(1'b1, 4'h1, 4'h2, 1'b1, 4'hE, 4'hD, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Drain the scoreboard within a bounded wait.
    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      idle(1'b1);
      waited++;
    end
    check("queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/signed_add_arbiter.md
SIGNED_ADD_ARBITER -- requirements
Module: signed_add_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand/result width in bits (two's complement), legal range 2..32.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester 0/1 presents an operand pair.
REQ-005 SHALL have ports req0_a, req0_b / req1_a, req1_b  input  WIDTH  signed operands of requester 0/1.
REQ-006 SHALL have ports req0_ready / req1_ready  output  1  requester 0/1 pair accepted this cycle.
REQ-007 SHALL have port res_valid  output  1  result register holds an undelivered result.
REQ-008 SHALL have port res_ready  input  1  consumer accepts result.
REQ-009 SHALL have port res_sum  output  WIDTH  a+b modulo 2^WIDTH.
REQ-010 SHALL have port res_overflow  output  1  signed overflow of that addition.
REQ-011 SHALL have port res_id  output  1  index of requester that produced the result.
REQ-012 SHALL have port ovf_clear  input  1  synchronous clear of ovf_cnt.
REQ-013 SHALL have port ovf_cnt  output  8  number of accepted operations that overflowed.

Function
REQ-014 SHALL contain exactly one shared WIDTH-bit signed adder serving both requesters.
REQ-015 SHALL define overflow = (a[MSB]==b[MSB]) and (sum[MSB]!=a[MSB]); sum SHALL wrap, never saturate.
REQ-016 SHALL hold one result register (res_valid/res_sum/res_overflow/res_id); no other buffering.
REQ-017 SHALL have can_accept = !res_valid or (res_valid and res_ready).
REQ-018 SHALL grant at most one requester per cycle; reqN_ready = grantN and can_accept, combinational; reqN_ready SHALL never depend on reqN_ready of the other side.
REQ-019 Arbitration SHALL be round-robin: only one valid -> it is granted; both valid -> requester not granted at last accepted transfer is granted.
REQ-020 Last-grant pointer SHALL update only on an accepted transfer (valid and ready); stalled cycles leave it unchanged.
REQ-021 On accepted transfer, result register SHALL load sum/overflow/id, res_valid=1 on next edge (latency 1 cycle).
REQ-022 Delivery and new acceptance in same cycle SHALL give back-to-back results, one per cycle, no bubble.
REQ-023 res_valid and res_ready=0 -> result outputs SHALL hold stable; both reqN_ready SHALL be 0.
REQ-024 res_valid and res_ready=1 with no request -> res_valid SHALL fall to 0 next edge; res_sum/overflow/id MAY hold old values.
REQ-025 Requester dropping valid without ready SHALL be legal; no state change results.
REQ-026 ovf_cnt SHALL increment by 1 for each accepted transfer with overflow=1, saturate at 255.
REQ-027 ovf_clear and increment in same cycle -> ovf_cnt SHALL become 0 (clear wins).

Reset
REQ-028 rst_n low SHALL immediately force res_valid=0, res_sum=0, res_overflow=0, res_id=0, ovf_cnt=0, pointer = "last grant was 1" (requester 0 wins first contention).
REQ-029 While rst_n low, req0_ready and req1_ready SHALL be 0.
REQ-030 Reset asserted mid-operation SHALL discard any pending result; first accepted transfer after release behaves as after power-up.

Verification
REQ-031 WIDTH=4, req0 a=7 b=1, res_ready=1 -> next cycle res_sum=8 (-8), res_overflow=1, res_id=0, ovf_cnt=1.
REQ-032 req1 a=-8 b=-1 -> res_sum=7, res_overflow=1; req0 a=5 b=-3 -> res_sum=2, res_overflow=0.
REQ-033 Both valid continuously 4 cycles after reset, res_ready=1 -> res_id sequence 0,1,0,1, one result per cycle.
REQ-034 res_valid=1, res_ready=0 for 3 cycles with both requesting -> outputs stable, both ready=0, pointer unchanged; res_ready=1 -> resumes with correct alternation.
REQ-035 256 overflowing ops -> ovf_cnt holds 255; ovf_clear with simultaneous overflow op -> ovf_cnt=0.
REQ-036 rst_n pulsed low while res_valid=1 -> res_valid=0 immediately, ovf_cnt=0; next contention grants req0.
